// File: rtl/pll_reset_seq_pkg.sv
// pll_reset_seq_pkg: FSM state encoding and default parameters
// shared by the PLL reset sequencer and its bench.
package pll_reset_seq_pkg;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam int HOLD_CYCLES_DEF = 1024;
    localparam int LOSS_FILTER_DEF = 4;
    localparam int CNT_W_DEF       = 8;
    localparam int HB_DIV_DEF      = 51000000;

endpackage

// File: rtl/pll_reset_seq_if.sv
// pll_reset_seq_if: raw PLL lock in, reset/status out.
// master = PLL/board side, slave = sequencer.
interface pll_reset_seq_if #(
    parameter int CNT_W = 8
);
    logic             pll_lock;
    logic             rst_out;
    logic             ready;
    logic [CNT_W-1:0] loss_count;
    logic             heartbeat;

    modport master (
        output pll_lock,
        input  rst_out, ready, loss_count, heartbeat
    );

    modport slave (
        input  pll_lock,
        output rst_out, ready, loss_count, heartbeat
    );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser, async active-low reset to 0.
// Ports: i_clk, i_rst_n, i_d (async in), o_q (synchronised out).
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;
endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: turns async PLL LOCK into a filtered active-high
// reset, ready flag and saturating lock-loss counter.
// Ports: clock, reset_n (async, active low), bus (slave modport:
// pll_lock in; rst_out, ready, loss_count, heartbeat out).
// Optional heartbeat blinker: define PLL_RESET_SEQ_HEARTBEAT_EN.
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int LOSS_FILTER = LOSS_FILTER_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int HB_DIV      = HB_DIV_DEF
) (
    input  logic           clock,
    input  logic           reset_n,
    pll_reset_seq_if.slave bus
);
    localparam int MAXC = (HOLD_CYCLES > LOSS_FILTER) ?
                          HOLD_CYCLES : LOSS_FILTER;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] LOSS_END = CW'(LOSS_FILTER);

    if (HOLD_CYCLES < 1 || LOSS_FILTER < 1 || HB_DIV < 1)
    begin : g_bad_param
        $error("pll_reset_seq: parameters must be >= 1");
    end

    logic             w_lock;
    logic [CW-1:0]    w_cnt_inc;
    logic [CNT_W-1:0] w_loss_inc;
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_rst;
    logic             r_ready;
    logic [CNT_W-1:0] r_loss;

    sync_2ff #(.W(1)) u_sync (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_d     (bus.pll_lock),
        .o_q     (w_lock)
    );

    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_loss_inc = (r_loss == '1) ? r_loss : r_loss + 1'b1;

    // HOLD and DROP share one counter; outputs follow next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
            r_rst   <= 1'b1;
            r_ready <= 1'b0;
            r_loss  <= '0;
        end else begin
            unique case (r_state)
                S_WAIT: begin
                    if (w_lock) begin
                        if (HOLD_CYCLES == 1) begin
                            r_state <= S_RUN;
                            r_rst   <= 1'b0;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= S_HOLD;
                            r_cnt   <= CW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (!w_lock) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == HOLD_END) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_rst   <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                S_RUN: begin
                    if (!w_lock) begin
                        if (LOSS_FILTER == 1) begin
                            r_state <= S_WAIT;
                            r_rst   <= 1'b1;
                            r_ready <= 1'b0;
                            r_loss  <= w_loss_inc;
                        end else begin
                            r_state <= S_DROP;
                            r_cnt   <= CW'(1);
                        end
                    end
                end
                S_DROP: begin
                    if (w_lock) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == LOSS_END) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                        r_rst   <= 1'b1;
                        r_ready <= 1'b0;
                        r_loss  <= w_loss_inc;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.rst_out    = r_rst;
    assign bus.ready      = r_ready;
    assign bus.loss_count = r_loss;

`ifdef PLL_RESET_SEQ_HEARTBEAT_EN
    localparam int DW = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
    localparam logic [DW-1:0] DIV_END = DW'(HB_DIV - 1);

    logic          w_nready;
    logic [DW-1:0] r_div;
    logic          r_hb;

    // Next-state ready, so the blinker stops on the same edge.
    always_comb begin
        w_nready = 1'b0;
        unique case (r_state)
            S_WAIT: w_nready = w_lock && (HOLD_CYCLES == 1);
            S_HOLD: w_nready = w_lock && (w_cnt_inc == HOLD_END);
            S_RUN:  w_nready = w_lock || (LOSS_FILTER != 1);
            S_DROP: w_nready = w_lock || (w_cnt_inc != LOSS_END);
            default: w_nready = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
            r_hb  <= 1'b0;
        end else if (!w_nready) begin
            r_div <= '0;
            r_hb  <= 1'b0;
        end else if (r_div == DIV_END) begin
            r_div <= '0;
            r_hb  <= ~r_hb;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign bus.heartbeat = r_hb;
`else
    assign bus.heartbeat = 1'b0;
`endif
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed + random lock stimulus against a
// run-length behavioural model; two DUTs differ only in CNT_W.
module tb_pll_reset_seq;
    localparam int HOLD = 16;
    localparam int LF   = 4;
    localparam int HB   = 5;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic lock    = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    pll_reset_seq_if #(.CNT_W(8)) bus_a ();
    pll_reset_seq_if #(.CNT_W(2)) bus_b ();

    assign bus_a.pll_lock = lock;
    assign bus_b.pll_lock = lock;

    pll_reset_seq #(
        .HOLD_CYCLES (HOLD),
        .LOSS_FILTER (LF),
        .CNT_W       (8),
        .HB_DIV      (HB)
    ) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    pll_reset_seq #(
        .HOLD_CYCLES (HOLD),
        .LOSS_FILTER (LF),
        .CNT_W       (2),
        .HB_DIV      (HB)
    ) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    // Model: the FSM sees the lock sampled two edges earlier;
    // ready rises after HOLD seen-highs in a row, falls after LF
    // seen-lows in a row.
    bit samp[$];
    bit seen;
    bit m_ready;
    int m_run;
    int m_loss;
    int m_hbn;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            samp.delete();
            m_ready = 1'b0;
            m_run   = 0;
            m_loss  = 0;
            m_hbn   = 0;
        end else begin
            samp.push_back(lock);
            seen = (samp.size() >= 3) ? samp[samp.size()-3] : 1'b0;
            if (!m_ready) begin
                m_run = seen ? m_run + 1 : 0;
                if (m_run >= HOLD) begin
                    m_ready = 1'b1;
                    m_run   = 0;
                end
            end else begin
                m_run = seen ? 0 : m_run + 1;
                if (m_run >= LF) begin
                    m_ready = 1'b0;
                    m_run   = 0;
                    m_loss++;
                end
            end
            m_hbn = m_ready ? m_hbn + 1 : 0;
        end
    end

    function automatic void chk(string n, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d",
                     n, $time, act, exp);
        end
    endfunction

    function automatic int exp_hb();
`ifdef PLL_RESET_SEQ_HEARTBEAT_EN
        return (m_hbn / HB) % 2;
`else
        return 0;
`endif
    endfunction

    always @(negedge clock) begin
        if (reset_n) begin
            chk("m_rst_a", int'(bus_a.rst_out), int'(!m_ready));
            chk("m_rdy_a", int'(bus_a.ready), int'(m_ready));
            chk("m_rdy_b", int'(bus_b.ready), int'(m_ready));
            chk("m_loss_a", int'(bus_a.loss_count),
                (m_loss > 255) ? 255 : m_loss);
            chk("m_loss_b", int'(bus_b.loss_count),
                (m_loss > 3) ? 3 : m_loss);
            chk("m_hb_a", int'(bus_a.heartbeat), exp_hb());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic rst_pulse();
        #2 reset_n = 1'b0;
        #1;
        chk("ar_rst", int'(bus_a.rst_out), 1);
        chk("ar_rdy", int'(bus_a.ready), 0);
        chk("ar_loss", int'(bus_a.loss_count), 0);
        chk("ar_hb", int'(bus_a.heartbeat), 0);
        #1 reset_n = 1'b1;
    endtask

    int exp_b [5] = '{1, 2, 3, 3, 3};

    initial begin
        lock    = 1'b1;
        reset_n = 1'b0;
        #12;
        chk("rs_rst", int'(bus_a.rst_out), 1);
        chk("rs_rdy", int'(bus_a.ready), 0);
        chk("rs_loss", int'(bus_a.loss_count), 0);
        chk("rs_hb", int'(bus_a.heartbeat), 0);
        reset_n = 1'b1;

        tick(17);
        chk("e17_rst", int'(bus_a.rst_out), 1);
        tick(1);
        chk("e18_rst", int'(bus_a.rst_out), 0);
        chk("e18_rdy", int'(bus_a.ready), 1);
        tick(5);

        lock = 1'b0;
        tick(3);
        lock = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("sd_rdy", int'(bus_a.ready), 1);
        end
        chk("sd_loss", int'(bus_a.loss_count), 0);

        lock = 1'b0;
        tick(5);
        chk("ls5_rst", int'(bus_a.rst_out), 0);
        tick(1);
        chk("ls6_rst", int'(bus_a.rst_out), 1);
        chk("ls6_loss", int'(bus_a.loss_count), 1);
        tick(2);
        lock = 1'b1;
        tick(17);
        chk("rl17_rst", int'(bus_a.rst_out), 1);
        tick(1);
        chk("rl18_rst", int'(bus_a.rst_out), 0);
        tick(3);

        rst_pulse();
        tick(10);
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        tick(17);
        chk("gl28_rst", int'(bus_a.rst_out), 1);
        tick(1);
        chk("gl29_rst", int'(bus_a.rst_out), 0);
        tick(7);

        for (int i = 0; i < 5; i++) begin
            lock = 1'b0;
            tick(6);
            chk("sat_b", int'(bus_b.loss_count), exp_b[i]);
            chk("sat_a", int'(bus_a.loss_count), i + 1);
            lock = 1'b1;
            tick(20);
        end

        rst_pulse();

        for (int i = 0; i < 200; i++) begin
            lock = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 24));
            if (i == 100) rst_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Consumer-side companion to the board PLL: runs in the PLL output clock domain and turns the PLL's asynchronous LOCK signal into a clean, active-high design reset.
- Synchronises lock, requires a stable lock period before releasing reset, and filters short lock dropouts.
- Counts genuine lock-loss events for debug LEDs and UART status.
- Sits between the PLL instance and the top-level Silice design's reset input.

Parameters:
- HOLD_CYCLES, 1024, consecutive synchronised-lock-high cycles required before reset is released; must be >= 1.
- LOSS_FILTER, 4, consecutive synchronised-lock-low cycles in RUN that count as a real loss; must be >= 1.
- CNT_W, 8, width of loss_count.
- HB_DIV, 51000000, heartbeat half-period in cycles; used only with the optional feature.

Ports:
- clock  in  1  PLL output clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  raw PLL LOCK; asynchronous to clock.
- rst_out  out  1  active-high reset to the design; registered.
- ready  out  1  high exactly while the FSM is in RUN or DROP; registered.
- loss_count  out  CNT_W  saturating count of confirmed lock losses.
- heartbeat  out  1  blink output; constant 0 unless the feature is enabled.

Behaviour:
- Async reset (reset_n low): sync flops=0, state=WAIT, counter=0, rst_out=1, ready=0, loss_count=0, heartbeat=0.
  - Takes effect immediately, without a clock edge, including mid-RUN.
- Synchroniser: two flops, pll_lock -> s1 -> lock_s. The FSM uses only lock_s.
- Counter cnt: width $clog2(max(HOLD_CYCLES, LOSS_FILTER)+1); shared between HOLD and DROP.
- WAIT (rst_out=1, ready=0):
  - lock_s=1 -> if HOLD_CYCLES==1 go RUN, else go HOLD with cnt=1.
- HOLD (rst_out=1):
  - lock_s=0 -> WAIT, cnt=0.
  - lock_s=1 -> cnt+1; on the edge where cnt+1==HOLD_CYCLES -> RUN.
  - The hold restarts fully after any glitch.
- RUN (rst_out=0, ready=1):
  - lock_s=0 -> if LOSS_FILTER==1 go WAIT, else go DROP with cnt=1.
- DROP (rst_out=0, ready=1):
  - lock_s=1 -> RUN, cnt=0; loss_count unchanged.
  - lock_s=0 -> cnt+1; on the edge where cnt+1==LOSS_FILTER -> WAIT, loss_count+1.
- Outputs are registered from next-state and change on the same edge as the state.
- Latency from the first edge sampling pll_lock high (stable): rst_out falls on edge HOLD_CYCLES+2.
- Latency from the first edge sampling pll_lock low in RUN (held low): rst_out rises on edge LOSS_FILTER+2.
- loss_count saturates at 2^CNT_W-1 and never wraps. It is cleared only by reset_n.
- Simultaneous events: the lock_s value sampled on an edge decides that edge's transition; there is no priority beyond the FSM.

Optional Feature:
- Macro: PLL_RESET_SEQ_HEARTBEAT_EN.
- Defined:
  - A divider counter runs only in RUN/DROP.
  - heartbeat toggles every HB_DIV cycles.
  - Entering WAIT clears the divider and forces heartbeat=0.
- Undefined: no divider logic; heartbeat tied to 0; HB_DIV unused.

Decomposition:
- Package pll_reset_seq_pkg: state enum (WAIT, HOLD, RUN, DROP, 2-bit encoding) and default parameter constants.
- One natural sub-module: sync_2ff (parameterised two-flop synchroniser, async active-low reset to 0), reused for other async board inputs.

Test Plan (HOLD_CYCLES=16, LOSS_FILTER=4, CNT_W=8 unless stated):
- reset_n released, pll_lock=1 throughout -> rst_out 1->0 and ready 0->1 on edge 18; loss_count=0.
- Lock high 10 edges, low 1 edge, then high -> rst_out stays 1; release comes 16 lock_s-high cycles after the glitch clears.
- In RUN, pll_lock low for 3 edges -> rst_out stays 0, ready stays 1, loss_count=0.
- In RUN, pll_lock low for 8 edges -> rst_out=1 on edge 6 after the first low sample; loss_count=1; re-lock releases after a full hold.
- CNT_W=2, five confirmed losses -> loss_count reads 1,2,3,3,3.
- reset_n pulsed low mid-RUN between clock edges -> rst_out=1, ready=0, loss_count=0 immediately.
  - With PLL_RESET_SEQ_HEARTBEAT_EN and HB_DIV=5, heartbeat toggles every 5 cycles in RUN and is 0 in WAIT.
